// File: rtl/mtr_ramp_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mtr_ramp_seq
// Description : Dual-channel (left/right) motor duty ramp sequencer.
//               Each side slews its signed 12-bit duty toward a latched
//               target by STEP once per ramp tick. Direction reversals go
//               through zero and hold there for DEAD_TICKS ticks before the
//               duty ramps the other way.
//
// Parameters  : TICK_DIV   - clocks per ramp tick (2..65535)
//               STEP       - duty magnitude change per tick (1..2047)
//               DEAD_TICKS - zero-hold ticks on direction reversal (1..255)
//
// Ports       : clk       in   system clock, rising edge
//               rst_n     in   asynchronous active-low reset
//               estop     in   emergency stop (only with MTR_RAMP_SEQ_ESTOP_EN)
//               lft_cmd   in   signed left target duty
//               rght_cmd  in   signed right target duty
//               cmd_vld   in   strobe that latches both commands
//               en        in   drive enable; low ramps both sides to 0
//               lft_duty  out  signed registered left duty
//               rght_duty out  signed registered right duty
//               busy      out  high while either side is not IDLE
//               at_tgt    out  one-cycle pulse when busy falls
//
// Build macro : MTR_RAMP_SEQ_ESTOP_EN - adds the estop input
//
// Revision    : 1.0 - initial release
// ============================================================================
module mtr_ramp_seq #(
    parameter int TICK_DIV   = 1024,
    parameter int STEP       = 16,
    parameter int DEAD_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef MTR_RAMP_SEQ_ESTOP_EN
    input  logic               estop,
`endif
    input  logic signed [11:0] lft_cmd,
    input  logic signed [11:0] rght_cmd,
    input  logic               cmd_vld,
    input  logic               en,
    output logic signed [11:0] lft_duty,
    output logic signed [11:0] rght_duty,
    output logic               busy,
    output logic               at_tgt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic [15:0]        c_tick_last = 16'(TICK_DIV - 1);
    localparam logic [7:0]         c_dead_last = 8'(DEAD_TICKS - 1);
    localparam logic signed [12:0] c_step      = 13'(STEP);

    // ------------------------------------------------------------------------
    // Emergency stop source; tied inactive when the feature is not built in
    // ------------------------------------------------------------------------
    logic w_estop;
`ifdef MTR_RAMP_SEQ_ESTOP_EN
    assign w_estop = estop;
`else
    assign w_estop = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Free-running ramp tick divider
    // ------------------------------------------------------------------------
    logic [15:0] r_tick_cnt;
    logic        w_tick;

    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-side sequencers. Side 0 is left, side 1 is right.
    // ------------------------------------------------------------------------
    logic [23:0] w_cmd_bus;
    logic [23:0] w_duty_bus;
    logic [1:0]  w_busy_nxt;

    assign w_cmd_bus = {rght_cmd, lft_cmd};

    for (genvar s = 0; s < 2; s++) begin : g_side
        state_t             r_state;
        state_t             w_state_nxt;
        logic signed [11:0] r_tgt;
        logic signed [11:0] r_duty;
        logic signed [11:0] w_duty_nxt;
        logic [7:0]         r_dead_cnt;
        logic [7:0]         w_dead_nxt;
        logic signed [11:0] w_cmd;
        logic signed [11:0] w_cmd_sat;
        logic signed [11:0] w_eff_tgt;
        logic signed [12:0] w_duty_x;
        logic signed [12:0] w_aim;
        logic signed [12:0] w_step;
        logic               w_opposite;

        assign w_cmd = w_cmd_bus[s*12 +: 12];

        // -2048 has no positive counterpart; pin it to -2047 so the driver
        // always sees a symmetric magnitude range.
        assign w_cmd_sat = (w_cmd == 12'sh800) ? 12'sh801 : w_cmd;

        // Disabling only changes what the ramp aims at; the stored target
        // survives so re-enabling resumes toward it.
        assign w_eff_tgt = en ? r_tgt : 12'sd0;

        assign w_duty_x = {r_duty[11], r_duty};

        // A reversal is only in progress when both ends are nonzero and
        // disagree in sign; zero on either end is a plain slew.
        assign w_opposite = (r_duty != 12'sd0) && (w_eff_tgt != 12'sd0) &&
                            (r_duty[11] != w_eff_tgt[11]);

        // During a reversal the immediate goal is zero, not the target.
        assign w_aim = w_opposite ? 13'sd0 : {w_eff_tgt[11], w_eff_tgt};

        // One step toward the aim, clamped so it lands exactly on it.
        // 13-bit math keeps duty +/- STEP from wrapping.
        always_comb begin
            w_step = w_duty_x;
            if (w_duty_x < w_aim) begin
                w_step = w_duty_x + c_step;
                if (w_step > w_aim) begin
                    w_step = w_aim;
                end
            end else begin
                w_step = w_duty_x - c_step;
                if (w_step < w_aim) begin
                    w_step = w_aim;
                end
            end
        end

        // Next-state and next-duty logic
        always_comb begin
            w_state_nxt = r_state;
            w_duty_nxt  = r_duty;
            w_dead_nxt  = r_dead_cnt;

            case (r_state)
                ST_IDLE: begin
                    if (r_duty != w_eff_tgt) begin
                        w_state_nxt = ST_RAMP;
                    end
                end

                ST_RAMP: begin
                    if (w_tick) begin
                        w_duty_nxt = w_step[11:0];
                        if (w_step == w_aim) begin
                            if (w_opposite) begin
                                w_state_nxt = ST_DEAD;
                                w_dead_nxt  = 8'd0;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end

                ST_DEAD: begin
                    // Hold length is fixed; target changes cannot cut it short.
                    w_duty_nxt = 12'sd0;
                    if (w_tick) begin
                        if (r_dead_cnt == c_dead_last) begin
                            w_dead_nxt  = 8'd0;
                            w_state_nxt = (w_eff_tgt == 12'sd0) ? ST_IDLE : ST_RAMP;
                        end else begin
                            w_dead_nxt = r_dead_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_duty_nxt  = 12'sd0;
                    w_dead_nxt  = 8'd0;
                end
            endcase

            if (w_estop) begin
                w_state_nxt = ST_IDLE;
                w_duty_nxt  = 12'sd0;
                w_dead_nxt  = 8'd0;
            end
        end

        // State, duty, dead counter and target registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= ST_IDLE;
                r_duty     <= 12'sd0;
                r_dead_cnt <= 8'd0;
                r_tgt      <= 12'sd0;
            end else begin
                r_state    <= w_state_nxt;
                r_duty     <= w_duty_nxt;
                r_dead_cnt <= w_dead_nxt;
                if (w_estop) begin
                    r_tgt <= 12'sd0;
                end else if (cmd_vld) begin
                    r_tgt <= w_cmd_sat;
                end
            end
        end

        assign w_duty_bus[s*12 +: 12] = r_duty;
        assign w_busy_nxt[s]          = (w_state_nxt != ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // Status: busy tracks the state registers exactly; at_tgt marks its fall
    // ------------------------------------------------------------------------
    logic r_busy;
    logic r_at_tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_at_tgt <= 1'b0;
        end else begin
            r_busy   <= |w_busy_nxt;
            r_at_tgt <= r_busy & ~(|w_busy_nxt);
        end
    end

    assign lft_duty  = w_duty_bus[11:0];
    assign rght_duty = w_duty_bus[23:12];
    assign busy      = r_busy;
    assign at_tgt    = r_at_tgt;

endmodule
`default_nettype wire

// File: tb/tb_mtr_ramp_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mtr_ramp_seq
// Description : Directed self-checking bench for mtr_ramp_seq with
//               TICK_DIV=4, STEP=16, DEAD_TICKS=2. Expected duty values and
//               their spacing in clocks are queued when a command is issued
//               and consumed whenever a duty output changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtr_ramp_seq;

    localparam int TICK_DIV   = 4;
    localparam int STEP       = 16;
    localparam int DEAD_TICKS = 2;

    logic               clk;
    logic               rst_n;
    logic signed [11:0] lft_cmd;
    logic signed [11:0] rght_cmd;
    logic               cmd_vld;
    logic               en;
    logic signed [11:0] lft_duty;
    logic signed [11:0] rght_duty;
    logic               busy;
    logic               at_tgt;
`ifdef MTR_RAMP_SEQ_ESTOP_EN
    logic               estop;
    initial estop = 1'b0;
`endif

    mtr_ramp_seq #(
        .TICK_DIV   (TICK_DIV),
        .STEP       (STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MTR_RAMP_SEQ_ESTOP_EN
        .estop     (estop),
`endif
        .lft_cmd   (lft_cmd),
        .rght_cmd  (rght_cmd),
        .cmd_vld   (cmd_vld),
        .en        (en),
        .lft_duty  (lft_duty),
        .rght_duty (rght_duty),
        .busy      (busy),
        .at_tgt    (at_tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [11:0] val;
        int                 gap;   // clocks since previous change, -1 = any
    } exp_t;

    exp_t               q_l[$];
    exp_t               q_r[$];
    int                 n_eval;
    int                 n_fail;
    int                 edges;
    int                 last_l;
    int                 last_r;
    int                 at_pulses;
    logic signed [11:0] prev_l;
    logic signed [11:0] prev_r;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_eval++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int side, input int val, input int gap);
        exp_t e;
        e.val = 12'(val);
        e.gap = gap;
        if (side == 0) q_l.push_back(e);
        else           q_r.push_back(e);
    endtask

    task automatic chk_change(input int side, input logic signed [11:0] obs);
        exp_t               e;
        logic signed [11:0] prev;
        int                 last;
        int                 n;
        string              t_val;
        string              t_gap;
        string              t_aln;
        t_val = (side == 0) ? "lft_value"      : "rght_value";
        t_gap = (side == 0) ? "lft_gap"        : "rght_gap";
        t_aln = (side == 0) ? "lft_tick_align" : "rght_tick_align";
        if (side == 0) begin prev = prev_l; last = last_l; n = q_l.size(); end
        else           begin prev = prev_r; last = last_r; n = q_r.size(); end
        if (n == 0) begin
            // nothing was expected: the duty should not have moved
            chk(t_val, obs, prev);
        end else begin
            if (side == 0) e = q_l.pop_front();
            else           e = q_r.pop_front();
            chk(t_val, obs, e.val);
            if (e.gap >= 0) chk(t_gap, edges - last, e.gap);
        end
        chk(t_aln, edges % TICK_DIV, 0);
        if (side == 0) begin prev_l = obs; last_l = edges; end
        else           begin prev_r = obs; last_r = edges; end
    endtask

    task automatic clk_chk();
        @(posedge clk);
        #1;
        edges++;
        if (at_tgt === 1'b1) at_pulses++;
        if (lft_duty !== prev_l)  chk_change(0, lft_duty);
        if (rght_duty !== prev_r) chk_change(1, rght_duty);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((q_l.size() + q_r.size()) != 0 && n < bound) begin
            clk_chk();
            n++;
        end
        chk("drain_timeout", (n < bound), 1);
    endtask

    task automatic settle();
        drain(1000);
        repeat (3) clk_chk();
    endtask

    task automatic send(input logic signed [11:0] l, input logic signed [11:0] r);
        lft_cmd  = l;
        rght_cmd = r;
        cmd_vld  = 1'b1;
        clk_chk();
        cmd_vld  = 1'b0;
    endtask

    initial begin
        n_eval = 0; n_fail = 0; edges = 0; last_l = 0; last_r = 0;
        at_pulses = 0; prev_l = 12'sd0; prev_r = 12'sd0;
        rst_n = 1'b0; en = 1'b0; cmd_vld = 1'b0; lft_cmd = 12'sd0; rght_cmd = 12'sd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_lft_duty", lft_duty, 0);
        chk("reset_rght_duty", rght_duty, 0);
        chk("reset_busy", busy, 0);
        chk("reset_at_tgt", at_tgt, 0);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // 0 -> +100: seven ticks, first tick four clocks after release
        for (int k = 1; k <= 6; k++) push(0, 16 * k, 4);
        push(0, 100, 4);
        send(12'sd100, 12'sd0);
        clk_chk();
        chk("ramp_busy_high", busy, 1);
        settle();
        chk("ramp_final", lft_duty, 100);
        chk("ramp_busy_low", busy, 0);
        chk("ramp_at_tgt_pulses", at_pulses, 1);
        at_pulses = 0;

        // +100 -> +64 (downward slew, final step clamped)
        push(0, 84, -1); push(0, 68, 4); push(0, 64, 4);
        send(12'sd64, 12'sd0);
        settle();
        chk("down_final", lft_duty, 64);
        chk("down_at_tgt_pulses", at_pulses, 1);
        at_pulses = 0;

        // +64 -> -64: through zero, two-tick dead hold, then negative
        push(0, 48, -1); push(0, 32, 4); push(0, 16, 4); push(0, 0, 4);
        push(0, -16, 4 * (DEAD_TICKS + 1));
        push(0, -32, 4); push(0, -48, 4); push(0, -64, 4);
        send(-12'sd64, 12'sd0);
        settle();
        chk("reverse_final", lft_duty, -64);
        chk("reverse_busy_low", busy, 0);
        chk("reverse_at_tgt_pulses", at_pulses, 1);
        at_pulses = 0;

        // -64 -> +200, drop en at +48, then re-enable
        push(0, -48, -1); push(0, -32, 4); push(0, -16, 4); push(0, 0, 4);
        push(0, 16, 4 * (DEAD_TICKS + 1)); push(0, 32, 4); push(0, 48, 4);
        send(12'sd200, 12'sd0);
        drain(1000);
        chk("en_mid_ramp_busy", busy, 1);
        en = 1'b0;
        push(0, 32, 4); push(0, 16, 4); push(0, 0, 4);
        settle();
        chk("en_low_final", lft_duty, 0);
        chk("en_low_at_tgt_pulses", at_pulses, 1);
        at_pulses = 0;
        en = 1'b1;
        push(0, 16, -1);
        for (int k = 2; k <= 12; k++) push(0, 16 * k, 4);
        push(0, 200, 4);
        settle();
        chk("en_resume_final", lft_duty, 200);
        chk("en_resume_at_tgt_pulses", at_pulses, 1);
        at_pulses = 0;

        // Right side -2048 saturates to -2047
        push(1, -16, -1);
        for (int k = 2; k <= 127; k++) push(1, -16 * k, 4);
        push(1, -2047, 4);
        send(12'sd200, -12'sd2048);
        settle();
        chk("sat_final", rght_duty, -2047);
        chk("sat_lft_unchanged", lft_duty, 200);
        chk("sat_at_tgt_pulses", at_pulses, 1);
        at_pulses = 0;

        // Reset mid-ramp, with the tick divider part way through a count
        push(0, 216, -1); push(0, 232, 4); push(0, 248, 4); push(0, 264, 4); push(0, 280, 4);
        send(12'sd300, -12'sd2047);
        drain(1000);
        repeat (2) clk_chk();
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_lft_duty", lft_duty, 0);
        chk("async_rst_rght_duty", rght_duty, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_at_tgt", at_tgt, 0);
        q_l.delete(); q_r.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0; last_l = 0; last_r = 0; prev_l = 12'sd0; prev_r = 12'sd0; at_pulses = 0;
        for (int k = 0; k < 3; k++) begin
            clk_chk();
            chk("post_rst_idle_busy", busy, 0);
        end
        // latched at clock 4, RAMP at 5, first step on the tick at clock 8
        push(0, 16, 8); push(0, 32, 4);
        send(12'sd32, 12'sd0);
        settle();
        chk("post_rst_final", lft_duty, 32);
        chk("post_rst_rght", rght_duty, 0);
        chk("post_rst_at_tgt_pulses", at_pulses, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mtr_ramp_seq.md
MTR_RAMP_SEQ -- requirements
Module: mtr_ramp_seq

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1024, clocks per ramp tick (range 2..65535).
REQ-002 SHALL have parameter STEP, default 16, duty magnitude change per tick (range 1..2047).
REQ-003 SHALL have parameter DEAD_TICKS, default 4, zero-hold ticks on direction reversal (range 1..255).
REQ-004 SHALL have port clk, input, 1, the single system clock; all flops use its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port lft_cmd, input, 12, signed two's-complement left target duty.
REQ-007 SHALL have port rght_cmd, input, 12, signed two's-complement right target duty.
REQ-008 SHALL have port cmd_vld, input, 1, one-cycle strobe that latches both commands.
REQ-009 SHALL have port en, input, 1, drive enable; low forces both targets to 0.
REQ-010 SHALL have port lft_duty, output, 12, signed registered left duty to the motor driver.
REQ-011 SHALL have port rght_duty, output, 12, signed registered right duty to the motor driver.
REQ-012 SHALL have port busy, output, 1, high while either side is not in IDLE.
REQ-013 SHALL have port at_tgt, output, 1, one-cycle pulse when busy falls.

Function
REQ-014 SHALL run a free tick counter 0..TICK_DIV-1 and assert an internal tick in the cycle the count equals TICK_DIV-1, then wrap to 0.
REQ-015 SHALL latch lft_cmd/rght_cmd into target registers at the edge where cmd_vld is high; a tick in that same cycle uses the old targets.
REQ-016 SHALL clamp a latched command of -2048 to -2047, so the driver never sees an unrepresentable magnitude.
REQ-017 SHALL use an effective target of 0 for both sides while en is low, without altering the stored targets.
REQ-018 SHALL run one independent FSM per side, states IDLE, RAMP, DEAD; duty updates occur only at the edge ending a tick cycle.
REQ-019 IDLE: duty equals effective target; on target mismatch go to RAMP (no output change in that cycle).
REQ-020 RAMP, same sign or duty 0: on each tick, move duty toward target by STEP, clamping exactly at target; on reaching it, go to IDLE.
REQ-021 RAMP, opposite nonzero signs: on each tick, move duty toward 0 by STEP, clamping at 0; on reaching 0, go to DEAD.
REQ-022 DEAD: hold duty at 0 for DEAD_TICKS ticks, then go to RAMP (or IDLE if target is 0); new commands during DEAD do not shorten it.
REQ-023 A new target mid-RAMP SHALL take effect on the next tick, with sign comparison re-evaluated against the current duty.
REQ-024 busy SHALL be registered; at_tgt SHALL pulse for exactly one cycle on busy 1->0.
REQ-025 Duty arithmetic SHALL use 13-bit signed intermediates so no step wraps past +/-2047.

Reset
REQ-026 SHALL, on rst_n low, immediately clear lft_duty, rght_duty, targets, tick counter, dead counters, busy and at_tgt to 0, and put both FSMs in IDLE.
REQ-027 Reset mid-ramp or mid-DEAD SHALL abandon the sequence; after release, the first tick occurs TICK_DIV clocks later.

Configuration
REQ-028 With MTR_RAMP_SEQ_ESTOP_EN defined, SHALL add input estop (1 bit): while high, both duties are forced to 0 at the next edge, targets are cleared, FSMs go to IDLE, and cmd_vld is ignored.
REQ-029 Without MTR_RAMP_SEQ_ESTOP_EN, SHALL have no estop port, and behaviour SHALL be exactly REQ-014..025.

Verification (TICK_DIV=4, STEP=16, DEAD_TICKS=2)
REQ-030 From reset, lft_cmd=+100 with cmd_vld and en=1 -> lft_duty goes 16,32,...,96,100 on 7 consecutive ticks; busy falls and at_tgt pulses once.
REQ-031 lft_duty=+64 settled, then lft_cmd=-64 -> duty goes 48,32,16,0, holds 0 for 2 ticks, then -16..-64 over 4 ticks.
REQ-032 rght_cmd=-2048 -> rght_duty settles at -2047, never at -2048.
REQ-033 Mid-ramp at duty 48 toward 200, en dropped -> duty ramps 32,16,0; re-raising en resumes the ramp toward 200.
REQ-034 rst_n pulsed low at duty 80 -> duty 0 asynchronously, with no tick until 4 clocks after release; with ESTOP_EN, estop high at duty 80 -> duty 0 at the next edge and commands ignored.
